// File: rtl/mips_ctrl_pkg.sv
// Purpose : shared opcode constants, memory/PC limits and sequencer state type for the MIPS control slice.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    localparam logic [5:0]  OP_MOV1   = 6'd56;     // single extra-cycle move
    localparam logic [5:0]  OP_MVLD   = 6'd57;     // move-load: reads the source
    localparam logic [5:0]  OP_MVST   = 6'd58;     // move-store: writes the destination

    localparam logic [15:0] MEM_TOP   = 16'd32764; // highest memory byte address; above is IO
    localparam logic [31:0] PC_LIMIT  = 32'd32764; // first illegal PC value
    localparam logic [1:0]  LONG_HOLD = 2'd3;      // hold cycles when memory is on both sides

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } seq_state_t;

endpackage

// File: rtl/move_hold_decoder.sv
// Purpose : maps an opcode/move address to its PC hold count, next src_is_mem flag and transfer type.
// Latency : purely combinational, 0 cycles.
// Backpressure: none; the caller decides when the decode is consumed.
//
// Ports:
//   op_code        - opcode of the instruction being decoded
//   move_data      - source or destination byte address (unsigned)
//   src_is_mem     - flag left by the most recent op 57
//   hold_n         - number of cycles the PC must be held (0 = no hold)
//   src_is_mem_nxt - value src_is_mem takes if this decode is accepted
//   is_xfer        - op is a two-phase transfer (57 or 58)
module move_hold_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]  op_code,
    input  logic [15:0] move_data,
    input  logic        src_is_mem,
    output logic [1:0]  hold_n,
    output logic        src_is_mem_nxt,
    output logic        is_xfer
);

    logic addr_is_mem;

    // Addresses up to and including MEM_TOP are memory; anything above is IO.
    assign addr_is_mem = (move_data <= MEM_TOP);

    always_comb begin
        hold_n         = 2'd0;
        src_is_mem_nxt = src_is_mem;
        is_xfer        = 1'b0;
        case (op_code)
            OP_MOV1: begin
                hold_n = 2'd1;
            end
            OP_MVLD: begin
                hold_n         = LONG_HOLD;
                src_is_mem_nxt = addr_is_mem;
                is_xfer        = 1'b1;
            end
            OP_MVST: begin
                // Memory-to-memory store needs the long hold; any IO side is a short one.
                hold_n         = (addr_is_mem && src_is_mem) ? LONG_HOLD : 2'd1;
                src_is_mem_nxt = 1'b0;
                is_xfer        = 1'b1;
            end
            default: begin
                hold_n = 2'd0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_move_sequencer.sv
// Purpose : holds the PC for multi-cycle move instructions, sequences read/write phases, raises sticky halt.
// Latency : pc_hold is Mealy in the decode cycle; an N-cycle hold occupies N+1 cycles in total.
// Backpressure: new instructions are ignored while busy or halted; pc_hold stalls the fetch side.
//
// Ports:
//   clk, rst      - rising-edge clock, asynchronous active-high reset
//   instr_valid   - op_code/move_data describe a newly fetched instruction
//   op_code       - opcode of the current instruction
//   move_data     - source/destination byte address of the move
//   pc_next       - PC value about to be loaded
//   pc_hold       - PC must not advance at the next edge
//   rd_phase      - decode cycle of op 57/58 (source read)
//   wr_phase      - final cycle of op 57/58 (destination write)
//   src_is_mem    - last op 57 read from memory
//   busy          - sequencer is in HOLD
//   halt          - sticky: pc_next reached PC_LIMIT
module multicycle_move_sequencer
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [5:0]  op_code,
    input  logic [15:0] move_data,
    input  logic [31:0] pc_next,
    output logic        pc_hold,
    output logic        rd_phase,
    output logic        wr_phase,
    output logic        src_is_mem,
    output logic        busy,
    output logic        halt
);

    seq_state_t state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    logic       src_is_mem_q;
    logic       halt_q;
    logic       xfer_q;        // latched at decode: current hold belongs to a 57/58

    logic [1:0] dec_hold_n;
    logic       dec_src_nxt;
    logic       dec_is_xfer;
    logic       decode_en;
    logic       hold_raw;      // hold demanded by sequencing, before halt forcing
    logic       halt_set;

    move_hold_decoder u_dec (
        .op_code        (op_code),
        .move_data      (move_data),
        .src_is_mem     (src_is_mem_q),
        .hold_n         (dec_hold_n),
        .src_is_mem_nxt (dec_src_nxt),
        .is_xfer        (dec_is_xfer)
    );

    // Decodes only happen from IDLE and never once halted.
    assign decode_en = (state == IDLE) && instr_valid && !halt_q;

    // Halt is only evaluated on cycles where the PC would actually advance.
    assign halt_set  = (pc_next >= PC_LIMIT) && !hold_raw;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 2'd0;
            src_is_mem_q <= 1'b0;
            halt_q       <= 1'b0;
            xfer_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (decode_en) begin
                src_is_mem_q <= dec_src_nxt;
                xfer_q       <= dec_is_xfer;
            end
            if (halt_set) begin
                halt_q <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (decode_en && (dec_hold_n != 2'd0)) begin
                    state_nxt = HOLD;
                    cnt_nxt   = dec_hold_n - 2'd1;
                end
            end
            HOLD: begin
                if (cnt == 2'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 2'd0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        hold_raw = 1'b0;
        rd_phase = 1'b0;
        wr_phase = 1'b0;
        case (state)
            IDLE: begin
                hold_raw = decode_en && (dec_hold_n != 2'd0);
                rd_phase = decode_en && dec_is_xfer;
            end
            HOLD: begin
                hold_raw = (cnt != 2'd0);
                wr_phase = (cnt == 2'd0) && xfer_q;
            end
            default: begin
                hold_raw = 1'b0;
            end
        endcase
    end

    assign pc_hold    = hold_raw || halt_q;
    assign busy       = (state == HOLD);
    assign src_is_mem = src_is_mem_q;
    assign halt       = halt_q;

endmodule

// File: tb/tb_multicycle_move_sequencer.sv
module tb_multicycle_move_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [5:0]  op_code;
    logic [15:0] move_data;
    logic [31:0] pc_next;
    logic        pc_hold;
    logic        rd_phase;
    logic        wr_phase;
    logic        src_is_mem;
    logic        busy;
    logic        halt;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] PL = 32'h0000_0100;
    localparam logic [31:0] PH = 32'd32764;

    // Expected output vector order: {pc_hold, rd_phase, wr_phase, src_is_mem, busy, halt}
    typedef struct {
        logic        v;
        logic [5:0]  op;
        logic [15:0] md;
        logic [31:0] pcn;
        logic [5:0]  exp;
    } vec_t;

    vec_t tbl[$];

    multicycle_move_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .op_code     (op_code),
        .move_data   (move_data),
        .pc_next     (pc_next),
        .pc_hold     (pc_hold),
        .rd_phase    (rd_phase),
        .wr_phase    (wr_phase),
        .src_is_mem  (src_is_mem),
        .busy        (busy),
        .halt        (halt)
    );

    always #5 clk = ~clk;

    task automatic add(input logic v, input logic [5:0] op, input logic [15:0] md,
                       input logic [31:0] pcn, input logic [5:0] exp);
        vec_t r;
        r.v = v; r.op = op; r.md = md; r.pcn = pcn; r.exp = exp;
        tbl.push_back(r);
    endtask

    task automatic check(input string nm, input logic [5:0] exp);
        logic [5:0] act;
        act = {pc_hold, rd_phase, wr_phase, src_is_mem, busy, halt};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {hold,rd,wr,src,busy,halt}=%b expected %b", nm, act, exp);
        end
    endtask

    // Called just after a posedge: drive one cycle, sample at negedge, advance.
    task automatic step(input vec_t r, input string nm);
        instr_valid = r.v;
        op_code     = r.op;
        move_data   = r.md;
        pc_next     = r.pcn;
        @(negedge clk);
        check(nm, r.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic step_v(input logic v, input logic [5:0] op, input logic [15:0] md,
                          input logic [31:0] pcn, input logic [5:0] exp, input string nm);
        vec_t r;
        r.v = v; r.op = op; r.md = md; r.pcn = pcn; r.exp = exp;
        step(r, nm);
    endtask

    initial begin
        // op 56: one hold cycle
        add(1, 6'd56, 16'h0000, PL, 6'b100000);
        add(0, 6'd0,  16'h0000, PL, 6'b000010);
        add(0, 6'd0,  16'h0000, PL, 6'b000000);
        // op 57 from memory, op 56 ignored while busy
        add(1, 6'd57, 16'h0100, PL, 6'b110000);
        add(0, 6'd0,  16'h0000, PL, 6'b100110);
        add(1, 6'd56, 16'h0000, PL, 6'b100110);
        add(0, 6'd0,  16'h0000, PL, 6'b001110);
        // op 58 mem->mem: long hold; halt condition inside hold is ignored
        add(1, 6'd58, 16'h0200, PL, 6'b110100);
        add(0, 6'd0,  16'h0000, PH, 6'b100010);
        add(0, 6'd0,  16'h0000, PH, 6'b100010);
        add(0, 6'd0,  16'h0000, PL, 6'b001010);
        // op 57 mem then op 58 to IO: short hold; halt condition on decode cycle ignored
        add(1, 6'd57, 16'h0100, PL, 6'b110000);
        add(0, 6'd0,  16'h0000, PL, 6'b100110);
        add(0, 6'd0,  16'h0000, PL, 6'b100110);
        add(0, 6'd0,  16'h0000, PL, 6'b001110);
        add(1, 6'd58, 16'h8000, PH, 6'b110100);
        add(0, 6'd0,  16'h0000, PL, 6'b001010);
        // op 57 from IO then op 58 to memory: short hold
        add(1, 6'd57, 16'h7FFD, PL, 6'b110000);
        add(0, 6'd0,  16'h0000, PL, 6'b100010);
        add(0, 6'd0,  16'h0000, PL, 6'b100010);
        add(0, 6'd0,  16'h0000, PL, 6'b001010);
        add(1, 6'd58, 16'h0010, PL, 6'b110000);
        add(0, 6'd0,  16'h0000, PL, 6'b001010);
        // boundary: 32764 is memory, 32765 is IO
        add(1, 6'd57, 16'h7FFC, PL, 6'b110000);
        add(0, 6'd0,  16'h0000, PL, 6'b100110);
        add(0, 6'd0,  16'h0000, PL, 6'b100110);
        add(0, 6'd0,  16'h0000, PL, 6'b001110);
        add(1, 6'd57, 16'h7FFD, PL, 6'b110100);
        add(0, 6'd0,  16'h0000, PL, 6'b100010);
        add(0, 6'd0,  16'h0000, PL, 6'b100010);
        add(0, 6'd0,  16'h0000, PL, 6'b001010);
        // two op 57s (IO then mem), then op 58 at MEM_TOP uses the latest flag
        add(1, 6'd57, 16'h8000, PL, 6'b110000);
        add(0, 6'd0,  16'h0000, PL, 6'b100010);
        add(0, 6'd0,  16'h0000, PL, 6'b100010);
        add(0, 6'd0,  16'h0000, PL, 6'b001010);
        add(1, 6'd57, 16'h7FFC, PL, 6'b110000);
        add(0, 6'd0,  16'h0000, PL, 6'b100110);
        add(0, 6'd0,  16'h0000, PL, 6'b100110);
        add(0, 6'd0,  16'h0000, PL, 6'b001110);
        add(1, 6'd58, 16'h7FFC, PL, 6'b110100);
        add(0, 6'd0,  16'h0000, PL, 6'b100010);
        add(0, 6'd0,  16'h0000, PL, 6'b100010);
        add(0, 6'd0,  16'h0000, PL, 6'b001010);
        // non-move opcode and invalid instruction: no hold
        add(1, 6'd5,  16'h0000, PL, 6'b000000);
        add(0, 6'd56, 16'h0000, PL, 6'b000000);
        // halt threshold
        add(0, 6'd0,  16'h0000, 32'd32760, 6'b000000);
        add(0, 6'd0,  16'h0000, PL, 6'b000000);
        add(0, 6'd0,  16'h0000, PH, 6'b000000);
        add(1, 6'd56, 16'h0000, PH, 6'b100001);
        add(1, 6'd57, 16'h0100, PL, 6'b100001);
        add(0, 6'd0,  16'h0000, PL, 6'b100001);

        // reset state
        rst = 1'b1; instr_valid = 1'b0; op_code = 6'd0; move_data = 16'h0; pc_next = PL;
        #1;
        check("reset", 6'b000000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            step(tbl[i], $sformatf("row%0d", i));
        end

        // halt is sticky until an asynchronous reset
        rst = 1'b1;
        #1;
        check("rst_clears_halt", 6'b000000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step_v(0, 6'd0, 16'h0, PL, 6'b000000, "after_halt_rst");

        // reset in the second HOLD cycle of op 57
        step_v(1, 6'd57, 16'h0100, PL, 6'b110000, "mid_op57_decode");
        step_v(0, 6'd0,  16'h0000, PL, 6'b100110, "mid_op57_hold1");
        instr_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_hold", 6'b000000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step_v(1, 6'd56, 16'h0000, PL, 6'b100000, "post_rst_op56_decode");
        step_v(0, 6'd0,  16'h0000, PL, 6'b000010, "post_rst_op56_hold");
        step_v(0, 6'd0,  16'h0000, PL, 6'b000000, "post_rst_op56_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
